// File: rtl/mii_tx_arbiter_if.sv
// Byte handshake bundle between the frame sources, the arbiter and the MII encoder.
interface mii_tx_arbiter_if #(
  parameter int unsigned NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]   req_valid;
  logic [8*NUM_PORTS-1:0] req_data;
  logic [NUM_PORTS-1:0]   req_last;
  logic [NUM_PORTS-1:0]   req_ready;
  logic                   tx_en;
  logic [7:0]             tx_data;
  logic                   tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_en, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_en, tx_data
  );
endinterface

// File: rtl/mii_tx_arbiter.sv
// Round-robin sharing of one MII transmit byte stream between NUM_PORTS frame sources,
// with idle gap enforcement, oversize truncation and underrun abort.
module mii_tx_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned MAX_BYTES  = 1514,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  mii_tx_arbiter_if.slave      bus,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 busy,
  output logic                 err_underrun,
  output logic                 err_oversize,
  output logic [15:0]          frames_sent
);
  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic [10:0]   byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = PW'((32'(rr_ptr) + i) % NUM_PORTS);
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign sel_valid     = bus.req_valid[owner];
  assign sel_last      = bus.req_last[owner];
  assign sel_data      = bus.req_data[{owner, 3'b000} +: 8];
  assign bus.req_ready = (state == S_SEND || state == S_DRAIN) ? grant : '0;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      grant        <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      bus.tx_en    <= 1'b0;
      bus.tx_data  <= '0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      frames_sent  <= '0;
    end else begin
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      bus.tx_en    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.tx_ready && win_found) begin
            grant    <= NUM_PORTS'(1) << win_idx;
            owner    <= win_idx;
            rr_ptr   <= (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
            byte_cnt <= '0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (sel_valid) begin
            bus.tx_en   <= 1'b1;
            bus.tx_data <= sel_data;
            if (sel_last) begin
              grant       <= '0;
              gap_cnt     <= '0;
              frames_sent <= frames_sent + 16'd1;
              state       <= S_GAP;
            end else if (byte_cnt == 11'(MAX_BYTES - 1)) begin
              // Forwarded byte becomes the truncated frame's last; the rest is drained.
              err_oversize <= 1'b1;
              state        <= S_DRAIN;
            end else begin
              byte_cnt <= byte_cnt + 11'd1;
            end
          end else begin
            err_underrun <= 1'b1;
            state        <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (sel_valid && sel_last) begin
            grant   <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Self-checking bench for mii_tx_arbiter: arbitration table, directed frame sequences,
// and randomized multi-port traffic checked against a frame-level reference model.
module tb_mii_tx_arbiter;
  localparam int NP   = 3;
  localparam int MAXB = 1514;
  localparam int GAP  = 4;

  typedef struct {
    logic [NP-1:0] vld;
    logic          rdy;
    logic [NP-1:0] exp_grant;
    logic [7:0]    exp_byte;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] grant;
  logic          busy;
  logic          err_underrun;
  logic          err_oversize;
  logic [15:0]   frames_sent;

  int tests    = 0;
  int fails    = 0;
  int m_ptr    = 0;
  int m_frames = 0;
  int glog[$];
  vec_t tbl[11];

  mii_tx_arbiter_if #(.NUM_PORTS(NP)) bus ();

  mii_tx_arbiter #(.NUM_PORTS(NP), .MAX_BYTES(MAXB), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus), .grant(grant), .busy(busy),
    .err_underrun(err_underrun), .err_oversize(err_oversize), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_req();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
  endtask

  task automatic wait_idle();
    clear_req();
    repeat (GAP + 2) tick();
  endtask

  function automatic logic [7:0] gen(input int k, input int f, input int p);
    return 8'(k * 71 + f * 29 + p * 13);
  endfunction

  // One source on port p streams bytes 0..len-1 (byte value = index), skipping
  // valid for one cycle at index 'hole' (-1: never). Collects what the encoder saw.
  task automatic run_single(input int p, input int len, input int hole,
                            output int grant_first, output int first_en, output int run_len,
                            output int runs, output int bad, output int n_under,
                            output int n_over, output bit done);
    int pos;
    bit holed, prev_en, hole_now;
    logic x;
    pos = 0; holed = 0; prev_en = 0; done = 0;
    grant_first = -1; first_en = -1; run_len = 0; runs = 0; bad = 0; n_under = 0; n_over = 0;
    bus.tx_ready = 1'b1;
    for (int cyc = 1; cyc <= 4000 && !done; cyc++) begin
      hole_now = (pos == hole) && !holed;
      clear_req();
      if (pos < len && !hole_now) begin
        bus.req_valid[p]       = 1'b1;
        bus.req_data[8*p +: 8] = 8'(pos);
        bus.req_last[p]        = (pos == len - 1);
      end
      #1 x = bus.req_valid[p] & bus.req_ready[p];
      tick();
      if (hole_now) holed = 1;
      if (x) pos++;
      if (grant != '0) begin
        if (grant_first < 0) grant_first = cyc;
        if (grant != (NP'(1) << p)) bad++;
      end
      if (bus.tx_en) begin
        if (first_en < 0) first_en = cyc;
        if (!prev_en) runs++;
        if (bus.tx_data != 8'(run_len)) bad++;
        run_len++;
      end
      n_under += int'(err_underrun);
      n_over  += int'(err_oversize);
      if (pos == len && !bus.tx_en) done = 1;
      prev_en = bus.tx_en;
    end
    m_ptr = (p + 1) % NP;
    clear_req();
  endtask

  // Multi-port traffic with a frame-level model: arbitration by the round-robin
  // rule, expected byte run per frame, error pulses and frame count.
  task automatic run_engine(input logic [NP-1:0] mask, input int fixed_len, input int hole_pct,
                            input int max_frames, input int rdy_pct, input int max_idle);
    int len[NP], pos[NP], hole[NP], fid[NP], wait_c[NP];
    bit act[NP], holed[NP], hole_now[NP];
    logic [NP-1:0] vld, x, prev_g, exp_g;
    logic rdy;
    bit prev_en, exp_rise, exp_under;
    logic [7:0] expq[$];
    logic [7:0] b;
    int started, finished, low_cnt, under_seen, over_seen, w, nb, fid_ctr;
    started = 0; finished = 0; fid_ctr = 0; under_seen = 0; over_seen = 0;
    low_cnt = GAP + 1; prev_g = '0; prev_en = 0; exp_under = 0;
    glog.delete();
    for (int k = 0; k < NP; k++) begin
      act[k] = 0; holed[k] = 0; wait_c[k] = 0; pos[k] = 0; len[k] = 1; hole[k] = -1; fid[k] = 0;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      for (int k = 0; k < NP; k++) begin
        if (!act[k] && mask[k] && started < max_frames) begin
          if (wait_c[k] > 0) wait_c[k]--;
          else begin
            act[k]   = 1; pos[k] = 0; holed[k] = 0;
            len[k]   = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 24));
            hole[k]  = -1;
            if (len[k] >= 2 && int'($urandom_range(0, 99)) < hole_pct)
              hole[k] = int'($urandom_range(1, len[k] - 1));
            fid[k]   = fid_ctr++;
            started++;
          end
        end
        hole_now[k]            = act[k] && pos[k] == hole[k] && !holed[k];
        vld[k]                 = act[k] && !hole_now[k];
        bus.req_valid[k]       = vld[k];
        bus.req_data[8*k +: 8] = gen(k, fid[k], pos[k]);
        bus.req_last[k]        = act[k] && pos[k] == len[k] - 1;
      end
      rdy = (int'($urandom_range(0, 99)) < rdy_pct);
      bus.tx_ready = rdy;
      #1 x = vld & bus.req_ready;
      tick();

      if (prev_g == '0) begin
        exp_rise = (low_cnt >= GAP + 1) && rdy && (vld != '0);
        check("arb_start", grant != '0, exp_rise);
        if (grant != '0) begin
          w = -1;
          for (int i = 0; i < NP; i++)
            if (w < 0 && vld[(m_ptr + i) % NP]) w = (m_ptr + i) % NP;
          exp_g = '0;
          if (w >= 0) exp_g[w] = 1'b1;
          check("arb_winner", grant, exp_g);
          if (w >= 0) begin
            m_ptr = (w + 1) % NP;
            glog.push_back(w);
            nb = (hole[w] >= 0) ? hole[w] : len[w];
            for (int i = 0; i < nb; i++) expq.push_back(gen(w, fid[w], i));
            exp_under = (hole[w] >= 0);
          end
          under_seen = 0; over_seen = 0;
        end
      end
      if (bus.tx_en) begin
        check("tx_byte_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          b = expq.pop_front();
          check("tx_data", bus.tx_data, b);
        end
      end
      if (prev_en && !bus.tx_en) check("tx_run_len_left", expq.size(), 0);
      under_seen += int'(err_underrun);
      over_seen  += int'(err_oversize);
      if (prev_g != '0 && grant == '0) begin
        check("frame_underrun", under_seen, exp_under);
        check("frame_oversize", over_seen, 0);
        if (!exp_under) m_frames++;
        check("frames_sent", frames_sent, 16'(m_frames));
        finished++;
      end
      low_cnt = (grant == '0) ? low_cnt + 1 : 0;
      for (int k = 0; k < NP; k++) begin
        if (hole_now[k]) holed[k] = 1;
        if (x[k]) begin
          pos[k]++;
          if (pos[k] == len[k]) begin
            act[k]    = 0;
            wait_c[k] = int'($urandom_range(0, max_idle));
          end
        end
      end
      prev_g  = grant;
      prev_en = bus.tx_en;
      if (finished >= max_frames && grant == '0 && !bus.tx_en) break;
    end
    check("engine_done", finished, max_frames);
    clear_req();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gf, fe, rl, rn, bd, nu, no, seen, p0;
    bit dn;
    logic x;

    tbl[0]  = '{3'b000, 1'b1, 3'b000, 8'h00};
    tbl[1]  = '{3'b111, 1'b0, 3'b000, 8'h00};
    tbl[2]  = '{3'b111, 1'b1, 3'b001, 8'hA0};
    tbl[3]  = '{3'b111, 1'b1, 3'b010, 8'hA1};
    tbl[4]  = '{3'b111, 1'b1, 3'b100, 8'hA2};
    tbl[5]  = '{3'b100, 1'b1, 3'b100, 8'hA2};
    tbl[6]  = '{3'b010, 1'b1, 3'b010, 8'hA1};
    tbl[7]  = '{3'b001, 1'b1, 3'b001, 8'hA0};
    tbl[8]  = '{3'b101, 1'b1, 3'b100, 8'hA2};
    tbl[9]  = '{3'b110, 1'b1, 3'b010, 8'hA1};
    tbl[10] = '{3'b011, 1'b1, 3'b001, 8'hA0};

    rst_n = 1'b0;
    clear_req();
    bus.tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_tx_en", bus.tx_en, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_err_u", err_underrun, 0);
    check("rst_err_o", err_oversize, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    tick();

    // Arbitration table: single-byte frames from a fresh round-robin pointer.
    for (int v = 0; v < 11; v++) begin
      bus.tx_ready = tbl[v].rdy;
      for (int k = 0; k < NP; k++) begin
        bus.req_valid[k]       = tbl[v].vld[k];
        bus.req_last[k]        = 1'b1;
        bus.req_data[8*k +: 8] = 8'hA0 + 8'(k);
      end
      tick();
      check($sformatf("tbl%0d_grant", v), grant, tbl[v].exp_grant);
      if (tbl[v].exp_grant != '0) begin
        check($sformatf("tbl%0d_ready", v), bus.req_ready, tbl[v].exp_grant);
        tick();
        m_frames++;
        check($sformatf("tbl%0d_tx_en", v), bus.tx_en, 1);
        check($sformatf("tbl%0d_tx_data", v), bus.tx_data, tbl[v].exp_byte);
        check($sformatf("tbl%0d_grant_off", v), grant, 0);
        check($sformatf("tbl%0d_frames", v), frames_sent, 16'(m_frames));
      end
      wait_idle();
    end

    // 64-byte frame, then an immediate follow-up that must wait out the gap.
    run_single(0, 64, -1, gf, fe, rl, rn, bd, nu, no, dn);
    m_frames++;
    check("f64_done", dn, 1);
    check("f64_grant_cyc", gf, 1);
    check("f64_first_en", fe, 2);
    check("f64_run_len", rl, 64);
    check("f64_runs", rn, 1);
    check("f64_bad", bd, 0);
    check("f64_errs", nu + no, 0);
    check("f64_frames", frames_sent, 16'(m_frames));
    run_single(0, 10, -1, gf, fe, rl, rn, bd, nu, no, dn);
    m_frames++;
    check("gap_grant_cyc", gf, GAP);
    check("gap_run_len", rl, 10);
    check("gap_frames", frames_sent, 16'(m_frames));

    // Underrun after 20 of 40 bytes.
    run_single(0, 40, 20, gf, fe, rl, rn, bd, nu, no, dn);
    check("ur_done", dn, 1);
    check("ur_run_len", rl, 20);
    check("ur_runs", rn, 1);
    check("ur_bad", bd, 0);
    check("ur_pulses", nu, 1);
    check("ur_oversize", no, 0);
    check("ur_frames", frames_sent, 16'(m_frames));

    // Oversize: 1600 offered, MAXB forwarded, rest drained.
    run_single(0, 1600, -1, gf, fe, rl, rn, bd, nu, no, dn);
    check("ov_done", dn, 1);
    check("ov_run_len", rl, MAXB);
    check("ov_runs", rn, 1);
    check("ov_bad", bd, 0);
    check("ov_pulses", no, 1);
    check("ov_underrun", nu, 0);
    check("ov_frames", frames_sent, 16'(m_frames));

    // Encoder not ready: no grant until tx_ready rises.
    wait_idle();
    bus.tx_ready           = 1'b0;
    bus.req_valid[1]       = 1'b1;
    bus.req_last[1]        = 1'b1;
    bus.req_data[15:8]     = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("txr0_grant", grant, 0);
      check("txr0_ready", bus.req_ready, 0);
    end
    bus.tx_ready = 1'b1;
    tick();
    check("txr1_grant", grant, 3'b010);
    tick();
    m_frames++;
    check("txr1_data", bus.tx_data, 8'h5A);
    m_ptr = 2;
    wait_idle();

    // Ports 0 and 1 back to back: grants alternate starting from port 0.
    run_engine(3'b011, 10, 0, 4, 100, 0);
    check("rr_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check($sformatf("rr_grant%0d", i), glog[i], i % 2);
    wait_idle();

    run_engine(3'b111, 0, 20, 60, 70, 4);
    wait_idle();
    run_engine(3'b101, 0, 0, 20, 100, 0);
    wait_idle();

    // Reset in the middle of a frame.
    bus.tx_ready = 1'b1;
    p0 = 0; seen = 0;
    for (int c = 0; c < 200 && seen < 30; c++) begin
      bus.req_valid[0] = 1'b1;
      bus.req_last[0]  = 1'b0;
      bus.req_data[7:0] = 8'(p0);
      #1 x = bus.req_ready[0];
      tick();
      if (x) p0++;
      if (bus.tx_en) seen++;
    end
    check("mid_bytes", seen, 30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en", bus.tx_en, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frames", frames_sent, 0);
    check("mid_rst_ready", bus.req_ready, 0);
    clear_req();
    tick();
    tick();
    rst_n = 1'b1;
    bus.req_valid = '1;
    bus.req_last  = '1;
    tick();
    check("post_rst_grant", grant, 3'b001);
    tick();
    clear_req();
    repeat (GAP + 2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
